// File: rtl/systolic_tile_ctrl.sv
// Sequencer for one systolic-array tile: loads ARRAY_M weight rows, streams
// num_vec input vectors with per-row diagonal skew, then drains the array.
// Optional feature macro: SYSTOLIC_TILE_CTRL_ABORT_EN adds abort/aborted.
module systolic_tile_ctrl #(
  parameter int unsigned ARRAY_M      = 4,
  parameter int unsigned ARRAY_N      = 4,
  parameter int unsigned LOG2_ARRAY_M = 2,
  parameter int unsigned VEC_W        = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [VEC_W-1:0]        num_vec,
`ifdef SYSTOLIC_TILE_CTRL_ABORT_EN
  input  logic                    abort,
  output logic                    aborted,
`endif
  output logic                    busy,
  output logic                    done,
  output logic                    w_rd_en,
  output logic [LOG2_ARRAY_M-1:0] w_rd_addr,
  output logic [ARRAY_M-1:0]      set_w,
  output logic                    x_rd_en,
  output logic [VEC_W-1:0]        x_rd_addr,
  output logic [ARRAY_M-1:0]      x_row_en,
  output logic [ARRAY_N-1:0]      psum_valid
);

  // The skew line covers one register per PE row (x path) plus one per column
  // (psum path); DRAIN lasts exactly as long as that line is deep.
  localparam int unsigned DLY_LEN = ARRAY_M + ARRAY_N;
  localparam int unsigned DRAIN_W = $clog2(DLY_LEN + 1);

  localparam logic [DRAIN_W-1:0]      DRAIN_LAST = DRAIN_W'(DLY_LEN - 1);
  localparam logic [LOG2_ARRAY_M-1:0] ROW_LAST   = LOG2_ARRAY_M'(ARRAY_M - 1);
  localparam logic [ARRAY_M-1:0]      ROW_ONE    = ARRAY_M'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD_W,
    ST_STREAM,
    ST_DRAIN
  } state_t;

  state_t                  state_q, state_d;
  logic [VEC_W-1:0]        nv_q, nv_d;
  logic [DRAIN_W-1:0]      drain_q, drain_d;
  logic                    busy_d;
  logic                    done_d;
  logic                    w_rd_en_d;
  logic [LOG2_ARRAY_M-1:0] w_rd_addr_d;
  logic                    x_rd_en_d;
  logic [VEC_W-1:0]        x_rd_addr_d;
  logic [DLY_LEN-1:0]      dly_q;
  logic                    abort_hit;

`ifdef SYSTOLIC_TILE_CTRL_ABORT_EN
  // Abort only has meaning while a tile is in flight.
  assign abort_hit = abort && busy;
`else
  assign abort_hit = 1'b0;
`endif

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_d     = state_q;
    nv_d        = nv_q;
    drain_d     = drain_q;
    done_d      = 1'b0;
    w_rd_en_d   = 1'b0;
    w_rd_addr_d = w_rd_addr;
    x_rd_en_d   = 1'b0;
    x_rd_addr_d = x_rd_addr;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_LOAD_W;
          nv_d        = num_vec;
          w_rd_en_d   = 1'b1;
          w_rd_addr_d = '0;
          x_rd_addr_d = '0;
        end
      end
      ST_LOAD_W: begin
        if (w_rd_addr == ROW_LAST) begin
          if (nv_q != '0) begin
            state_d     = ST_STREAM;
            x_rd_en_d   = 1'b1;
            x_rd_addr_d = '0;
          end else begin
            state_d = ST_DRAIN;
            drain_d = DRAIN_LAST;
          end
        end else begin
          w_rd_en_d   = 1'b1;
          w_rd_addr_d = w_rd_addr + LOG2_ARRAY_M'(1);
        end
      end
      ST_STREAM: begin
        // Leave on the last index, so the address never advances past num_vec-1.
        if (x_rd_addr == nv_q - VEC_W'(1)) begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_LAST;
        end else begin
          x_rd_en_d   = 1'b1;
          x_rd_addr_d = x_rd_addr + VEC_W'(1);
        end
      end
      ST_DRAIN: begin
        if (drain_q == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q - DRAIN_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort_hit) begin
      state_d     = ST_IDLE;
      drain_d     = '0;
      done_d      = 1'b0;
      w_rd_en_d   = 1'b0;
      w_rd_addr_d = '0;
      x_rd_en_d   = 1'b0;
      x_rd_addr_d = '0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State, counters and registered control outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      nv_q      <= '0;
      drain_q   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      w_rd_en   <= 1'b0;
      w_rd_addr <= '0;
      x_rd_en   <= 1'b0;
      x_rd_addr <= '0;
    end else begin
      state_q   <= state_d;
      nv_q      <= nv_d;
      drain_q   <= drain_d;
      busy      <= busy_d;
      done      <= done_d;
      w_rd_en   <= w_rd_en_d;
      w_rd_addr <= w_rd_addr_d;
      x_rd_en   <= x_rd_en_d;
      x_rd_addr <= x_rd_addr_d;
    end
  end

  // Weight latch strobe: the row read last cycle is now on the buffer output.
  always_ff @(posedge clk) begin
    if (rst || abort_hit) begin
      set_w <= '0;
    end else if (w_rd_en) begin
      set_w <= ROW_ONE << w_rd_addr;
    end else begin
      set_w <= '0;
    end
  end

  // Diagonal skew line fed by x_rd_en; runs in every state.
  always_ff @(posedge clk) begin
    if (rst || abort_hit) begin
      dly_q <= '0;
    end else begin
      dly_q <= {dly_q[DLY_LEN-2:0], x_rd_en};
    end
  end

  assign x_row_en   = dly_q[ARRAY_M-1:0];
  assign psum_valid = dly_q[DLY_LEN-1:ARRAY_M];

`ifdef SYSTOLIC_TILE_CTRL_ABORT_EN
  // One-cycle acknowledge of an accepted abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      aborted <= 1'b0;
    end else begin
      aborted <= abort_hit;
    end
  end
`endif

endmodule

// File: tb/tb_systolic_tile_ctrl.sv
// Self-checking bench for systolic_tile_ctrl: directed tiles plus random
// start/reset/abort traffic compared against a tile-timeline reference model.
module tb_systolic_tile_ctrl;

  localparam int unsigned M     = 4;
  localparam int unsigned N     = 4;
  localparam int unsigned LM    = 2;
  localparam int unsigned VEC_W = 8;
  localparam int          NEVER = 32'h3fff_ffff;

  logic             clk;
  logic             rst;
  logic             start;
  logic [VEC_W-1:0] num_vec;
  logic             busy;
  logic             done;
  logic             w_rd_en;
  logic [LM-1:0]    w_rd_addr;
  logic [M-1:0]     set_w;
  logic             x_rd_en;
  logic [VEC_W-1:0] x_rd_addr;
  logic [M-1:0]     x_row_en;
  logic [N-1:0]     psum_valid;
`ifdef SYSTOLIC_TILE_CTRL_ABORT_EN
  logic             abort;
  logic             aborted;
`endif

  systolic_tile_ctrl #(
    .ARRAY_M(M), .ARRAY_N(N), .LOG2_ARRAY_M(LM), .VEC_W(VEC_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .num_vec(num_vec),
`ifdef SYSTOLIC_TILE_CTRL_ABORT_EN
    .abort(abort),
    .aborted(aborted),
`endif
    .busy(busy),
    .done(done),
    .w_rd_en(w_rd_en),
    .w_rd_addr(w_rd_addr),
    .set_w(set_w),
    .x_rd_en(x_rd_en),
    .x_rd_addr(x_rd_addr),
    .x_row_en(x_row_en),
    .psum_valid(psum_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each accepted tile is a start cycle, a vector count, and the last cycle
  // whose outputs it still owns (cut short by reset or abort).
  typedef struct {
    int s;
    int nv;
    int kill;
  } tile_t;

  tile_t tiles[$];
  int    checks;
  int    failures;
  int    cyc;
  int    abort_cyc;

  logic         e_busy, e_done, e_w_en, e_x_en, e_aborted;
  int           e_w_addr, e_x_addr;
  logic [M-1:0] e_set_w, e_row_en;
  logic [N-1:0] e_psum;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Expected outputs at cycle t from the timeline of every live tile.
  task automatic expect_at(input int t);
    e_busy = 0; e_done = 0; e_w_en = 0; e_x_en = 0;
    e_w_addr = 0; e_x_addr = 0; e_set_w = '0; e_row_en = '0; e_psum = '0;
    e_aborted = (t == abort_cyc);
    for (int i = 0; i < tiles.size(); i++) begin
      int d;
      int nv;
      d  = t - tiles[i].s;
      nv = tiles[i].nv;
      if (t <= tiles[i].kill && d >= 1) begin
        if (d <= 2*M + N + nv) e_busy = 1;
        if (d == 2*M + N + nv + 1) e_done = 1;
        if (d <= M) begin
          e_w_en   = 1;
          e_w_addr = d - 1;
        end
        if (d >= M + 1 && d <= M + nv) begin
          e_x_en   = 1;
          e_x_addr = d - M - 1;
        end
        for (int r = 0; r < M; r++) begin
          if (d == 2 + r) e_set_w[r] = 1'b1;
          if (d >= M + 2 + r && d <= M + 1 + r + nv) e_row_en[r] = 1'b1;
        end
        for (int c = 0; c < N; c++) begin
          if (d >= 2*M + 2 + c && d <= 2*M + 1 + c + nv) e_psum[c] = 1'b1;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("busy", 32'(busy), 32'(e_busy));
    check("done", 32'(done), 32'(e_done));
    check("w_rd_en", 32'(w_rd_en), 32'(e_w_en));
    if (e_w_en) check("w_rd_addr", 32'(w_rd_addr), 32'(e_w_addr));
    check("set_w", 32'(set_w), 32'(e_set_w));
    check("x_rd_en", 32'(x_rd_en), 32'(e_x_en));
    if (e_x_en) check("x_rd_addr", 32'(x_rd_addr), 32'(e_x_addr));
    check("x_row_en", 32'(x_row_en), 32'(e_row_en));
    check("psum_valid", 32'(psum_valid), 32'(e_psum));
`ifdef SYSTOLIC_TILE_CTRL_ABORT_EN
    check("aborted", 32'(aborted), 32'(e_aborted));
`endif
  endtask

  // One clock: drive inputs, check outputs mid-cycle, then fold inputs into the model.
  task automatic step(input logic st, input int nv, input logic rs, input logic ab);
    start   = st;
    num_vec = VEC_W'(nv);
    rst     = rs;
`ifdef SYSTOLIC_TILE_CTRL_ABORT_EN
    abort   = ab;
`endif
    while (tiles.size() > 0 &&
           (cyc > tiles[0].kill || cyc > tiles[0].s + 2*M + N + tiles[0].nv + 1))
      void'(tiles.pop_front());
    @(negedge clk);
    expect_at(cyc);
    compare_all();
    if (rs) begin
      foreach (tiles[i]) if (tiles[i].kill > cyc) tiles[i].kill = cyc;
    end else begin
`ifdef SYSTOLIC_TILE_CTRL_ABORT_EN
      if (ab && e_busy) begin
        foreach (tiles[i]) if (tiles[i].kill > cyc) tiles[i].kill = cyc;
        abort_cyc = cyc + 1;
      end
`else
      if (ab) begin end
`endif
      if (st && !e_busy) tiles.push_back('{s: cyc, nv: nv, kill: NEVER});
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    cyc       = 0;
    abort_cyc = -1;
    rst       = 1'b1;
    start     = 1'b0;
    num_vec   = '0;
`ifdef SYSTOLIC_TILE_CTRL_ABORT_EN
    abort     = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_w_rd_en", 32'(w_rd_en), 32'd0);
    check("rst_w_rd_addr", 32'(w_rd_addr), 32'd0);
    check("rst_set_w", 32'(set_w), 32'd0);
    check("rst_x_rd_en", 32'(x_rd_en), 32'd0);
    check("rst_x_rd_addr", 32'(x_rd_addr), 32'd0);
    check("rst_x_row_en", 32'(x_row_en), 32'd0);
    check("rst_psum_valid", 32'(psum_valid), 32'd0);

    // num_vec=3, ignored start while busy, back-to-back start in the done cycle
    step(1'b1, 3, 1'b0, 1'b0);
    idle(7);
    step(1'b1, 5, 1'b0, 1'b0);
    idle(7);
    step(1'b1, 1, 1'b0, 1'b0);
    idle(16);

    // num_vec=0: weights only
    step(1'b1, 0, 1'b0, 1'b0);
    idle(15);

    // reset mid-STREAM, then a clean tile
    step(1'b1, 3, 1'b0, 1'b0);
    idle(5);
    step(1'b0, 0, 1'b1, 1'b0);
    idle(1);
    step(1'b1, 3, 1'b0, 1'b0);
    idle(20);

    // longest tile: x_rd_addr runs to its maximum without overflow
    step(1'b1, 255, 1'b0, 1'b0);
    idle(275);

`ifdef SYSTOLIC_TILE_CTRL_ABORT_EN
    // abort mid-tile, abort in IDLE, abort together with start in IDLE
    step(1'b1, 3, 1'b0, 1'b0);
    idle(8);
    step(1'b0, 0, 1'b0, 1'b1);
    idle(20);
    step(1'b0, 0, 1'b0, 1'b1);
    idle(2);
    step(1'b1, 2, 1'b0, 1'b1);
    idle(20);
`endif

    // random traffic
    for (int i = 0; i < 2500; i++) begin
      logic st, rs, ab;
      int   nv;
      st = ($urandom_range(0, 3) == 0);
      nv = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 12));
      rs = ($urandom_range(0, 199) == 0);
      ab = ($urandom_range(0, 39) == 0);
      step(st, nv, rs, ab);
    end
    idle(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
